// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared widths, depth and entry type for the store buffer
//
// Purpose: default store-buffer depth, address/data widths and the buffered
// store entry record shared by the store buffer, its interface and sb_match.
package pipeline_pkg;

  localparam int SB_DEPTH = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - pipeline and memory-port signals of the store buffer
//
// Purpose: bundles the store/load request signals from the pipeline and the
// shared single-port data memory signals.
// Ports (slave = store buffer side):
//   st_valid/st_addr/st_data in, st_ready out   : committed store push
//   ld_valid/ld_addr in, ld_data/ld_hit/ld_stall : load lookup and result
//   empty out                                    : no buffered stores
//   Mem_address/Mem_read/Mem_write/Write_data out, Read_Data in : memory port
interface store_buffer_if;
  import pipeline_pkg::*;

  logic              st_valid;
  logic [ADDR_W-1:0] st_addr;
  logic [DATA_W-1:0] st_data;
  logic              st_ready;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_hit;
  logic              ld_stall;
  logic              empty;
  logic [ADDR_W-1:0] Mem_address;
  logic              Mem_read;
  logic              Mem_write;
  logic [DATA_W-1:0] Write_data;
  logic [DATA_W-1:0] Read_Data;

  modport slave (
    input  st_valid, st_addr, st_data, ld_valid, ld_addr, Read_Data,
    output st_ready, ld_data, ld_hit, ld_stall, empty,
           Mem_address, Mem_read, Mem_write, Write_data
  );

  modport master (
    output st_valid, st_addr, st_data, ld_valid, ld_addr, Read_Data,
    input  st_ready, ld_data, ld_hit, ld_stall, empty,
           Mem_address, Mem_read, Mem_write, Write_data
  );

endinterface

// File: rtl/sb_match.sv
// rtl/sb_match.sv - youngest-match search over the buffered stores
//
// Purpose: combinational store-to-load forwarding lookup over the buffer.
// Ports:
//   entries in : buffered {addr, data} entries, indexed by slot
//   valid   in : per-slot occupancy mask
//   head    in : slot of the oldest entry
//   ld_addr in : load word address
//   hit     out: some valid entry matches ld_addr
//   data    out: data of the youngest matching entry (0 when no hit)
module sb_match
  import pipeline_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  sb_entry_t                    entries [DEPTH],
  input  logic [DEPTH-1:0]             valid,
  input  logic [$clog2(DEPTH)-1:0]     head,
  input  logic [ADDR_W-1:0]            ld_addr,
  output logic                         hit,
  output logic [DATA_W-1:0]            data
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk from oldest to youngest; a later match overrides an earlier one,
  // so the youngest matching entry is what remains at the end.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (valid[idx] && entries[idx].addr == ld_addr) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - posted-store buffer with store-to-load forwarding
//
// Purpose: queues committed stores and drains them to data memory one per
// cycle when the shared port is free; loads are forwarded from the youngest
// matching store (incoming or buffered) or read from memory. A load miss owns
// the port unless the buffer is full, in which case the load stalls and the
// head store drains.
// Ports:
//   clk   in : clock, state updates on rising edge
//   reset in : synchronous active-high reset
//   bus       : store_buffer_if.slave (pipeline requests and memory port)
module store_buffer
  import pipeline_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input logic           clk,
  input logic           reset,
  store_buffer_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t        entries_q [DEPTH];
  logic [PW-1:0]    head_q, tail_q;
  logic [CW-1:0]    count_q;
  logic [DEPTH-1:0] valid;

  logic              st_ready, push, full;
  logic              bypass_hit, buf_hit, ld_act, hit, miss, mem_rd, drain;
  logic [DATA_W-1:0] buf_data, fwd_data;

  // Slot i is occupied when its distance from head is below count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PW'(i) - head_q} < count_q);
    end
  end

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries (entries_q),
    .valid   (valid),
    .head    (head_q),
    .ld_addr (bus.ld_addr),
    .hit     (buf_hit),
    .data    (buf_data)
  );

  assign full     = (count_q == CW'(DEPTH));
  assign st_ready = !reset && !full;
  assign push     = bus.st_valid && st_ready;

  // The incoming store is younger than every buffered entry, so it wins.
  assign bypass_hit = push && (bus.st_addr == bus.ld_addr);
  assign fwd_data   = bypass_hit ? bus.st_data : buf_data;

  assign ld_act = bus.ld_valid && !reset;
  assign hit    = ld_act && (bypass_hit || buf_hit);
  assign miss   = ld_act && !hit;
  assign mem_rd = miss && !full;
  assign drain  = !reset && (count_q != '0) && !mem_rd;

  assign bus.st_ready    = st_ready;
  assign bus.ld_hit      = hit;
  assign bus.ld_stall    = miss && full;
  assign bus.ld_data     = hit ? fwd_data : (mem_rd ? bus.Read_Data : '0);
  assign bus.empty       = reset || (count_q == '0);
  assign bus.Mem_read    = mem_rd;
  assign bus.Mem_write   = drain;
  assign bus.Mem_address = mem_rd ? bus.ld_addr : (drain ? entries_q[head_q].addr : '0);
  assign bus.Write_data  = drain ? entries_q[head_q].data : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push)  tail_q <= tail_q + 1'b1;
      if (drain) head_q <= head_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(drain);
    end
  end

  // Entry payload needs no reset: occupancy comes from head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      entries_q[tail_q] <= '{addr: bus.st_addr, data: bus.st_data};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;
  import pipeline_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if bus();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem     [0:63];
  logic [DATA_W-1:0] exp_mem [0:63];
  logic [ADDR_W-1:0] wr_log  [$];
  sb_entry_t         q       [$];
  int checks = 0;
  int errors = 0;
  int max_count = 0;

  // Memory writes on the falling edge.
  always @(negedge clk) begin
    if (bus.Mem_write === 1'b1) begin
      mem[bus.Mem_address[5:0]] <= bus.Write_data;
      wr_log.push_back(bus.Mem_address);
    end
  end
  assign bus.Read_Data = mem[bus.Mem_address[5:0]];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_cycle(input logic sv);
    @(posedge clk); #1;
    reset = 1'b1;
    bus.st_valid = sv; bus.st_addr = 32'd9; bus.st_data = 32'd99;
    bus.ld_valid = 1'b0; bus.ld_addr = '0;
    #2;
    check("rst_st_ready", bus.st_ready, 0);
    check("rst_mem_read", bus.Mem_read, 0);
    check("rst_mem_write", bus.Mem_write, 0);
    check("rst_mem_addr", bus.Mem_address, 0);
    check("rst_write_data", bus.Write_data, 0);
    check("rst_ld_hit", bus.ld_hit, 0);
    check("rst_ld_stall", bus.ld_stall, 0);
    check("rst_ld_data", bus.ld_data, 0);
    check("rst_empty", bus.empty, 1);
    q.delete();
  endtask

  // One clock of stimulus, checked against a queue-based model of the buffer.
  task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la);
    logic e_ready, e_push, e_hit, e_rd, e_stall, e_wr;
    logic [31:0] e_ld, e_addr, e_wd;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd;
    bus.ld_valid = lv; bus.ld_addr = la;

    e_ready = (q.size() < DEPTH);
    e_push  = sv && e_ready;
    e_hit   = 1'b0;
    e_ld    = '0;
    if (lv) begin
      if (e_push && sa == la) begin
        e_hit = 1'b1; e_ld = sd;
      end else begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (!e_hit && q[i].addr == la) begin
            e_hit = 1'b1; e_ld = q[i].data;
          end
        end
      end
    end
    e_rd    = lv && !e_hit && (q.size() < DEPTH);
    e_stall = lv && !e_hit && (q.size() == DEPTH);
    if (e_rd) e_ld = exp_mem[la[5:0]];
    e_wr   = (q.size() > 0) && !e_rd;
    e_addr = e_rd ? la : (e_wr ? q[0].addr : 32'd0);
    e_wd   = e_wr ? q[0].data : 32'd0;

    #2;
    check("st_ready", bus.st_ready, e_ready);
    check("ld_hit", bus.ld_hit, e_hit);
    check("ld_stall", bus.ld_stall, e_stall);
    check("mem_read", bus.Mem_read, e_rd);
    check("mem_write", bus.Mem_write, e_wr);
    check("mem_address", bus.Mem_address, e_addr);
    check("empty", bus.empty, q.size() == 0);
    if (e_wr || !e_rd) check("write_data", bus.Write_data, e_wd);
    if (lv && !e_stall) check("ld_data", bus.ld_data, e_ld);

    if (e_wr) begin
      exp_mem[q[0].addr[5:0]] = q[0].data;
      void'(q.pop_front());
    end
    if (e_push) q.push_back('{addr: sa, data: sd});
    if (q.size() > max_count) max_count = q.size();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
    bus.ld_valid = 1'b0; bus.ld_addr = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      exp_mem[i] = '0;
    end
    mem[7] = 32'd9;
    exp_mem[7] = 32'd9;

    reset_cycle(1'b0);
    reset_cycle(1'b1);

    // Three stores drained on consecutive cycles.
    cycle(1'b1, 32'd1, 32'd10, 1'b0, 32'd0);
    cycle(1'b1, 32'd2, 32'd20, 1'b0, 32'd0);
    cycle(1'b1, 32'd3, 32'd30, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    cycle(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    check("t1_mem3", mem[3], 32'd30);

    // Incoming-store bypass beats an older buffered store to the same address.
    cycle(1'b1, 32'd5, 32'd55, 1'b0, 32'd0);
    cycle(1'b1, 32'd5, 32'd66, 1'b1, 32'd5);
    idle(3);
    check("t2_mem5", mem[5], 32'd66);

    // Empty buffer, load miss served from memory.
    cycle(1'b0, 32'd0, 32'd0, 1'b1, 32'd7);

    // Fill while a missing load hogs the port; stall once full.
    for (int i = 0; i < 6; i++) cycle(1'b1, 32'd20 + i, 32'd100 + i, 1'b1, 32'd50);
    idle(5);

    // Pointer wrap: write order 0..5.
    wr_log.delete();
    for (int i = 0; i < 6; i++) cycle(1'b1, i, 32'd200 + i, 1'b0, 32'd0);
    idle(3);
    check("t5_wr_count", wr_log.size(), 6);
    for (int i = 0; i < 6 && i < wr_log.size(); i++) check("t5_wr_order", wr_log[i], i);

    // Reset discards undrained stores.
    cycle(1'b1, 32'd10, 32'd110, 1'b1, 32'd40);
    cycle(1'b1, 32'd11, 32'd111, 1'b1, 32'd40);
    cycle(1'b1, 32'd12, 32'd112, 1'b1, 32'd40);
    reset_cycle(1'b0);
    idle(3);
    check("t6_mem12", mem[12], 32'd0);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom,
            1'($urandom_range(0, 1)), $urandom_range(0, 15));
    end
    idle(6);

    check("max_count", (max_count <= DEPTH), 1);
    for (int i = 0; i < 64; i++) check("final_mem", mem[i], exp_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
